// File: rtl/mem_pass_sched.sv
// Multi-pass memory test scheduler: walks 0..LAST_ADDR once per pass, writing a pass-dependent pattern.
// Optional readback/compare phase is built when MEMSEQ_READBACK_EN is defined.
module mem_pass_sched #(
    parameter int                ADDR_W     = 15,
    parameter int                DATA_W     = 15,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = '1,
    parameter int                NUM_PASSES = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              mem_done_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              load_a_o,
    output logic              load_d_o,
    output logic              write_o,
    output logic              read_o,
    output logic [3:0]        pass_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              finish_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_D, S_WRITE, S_RD_A, S_READ, S_PASS_END, S_FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        pass_q, pass_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              at_last, last_pass;

    assign at_last   = (addr_q == LAST_ADDR);
    assign last_pass = (pass_q == 4'(NUM_PASSES - 1));

    // Odd passes invert the address, every pass adds its index.
    assign wdata_o = (DATA_W'(addr_q) ^ {DATA_W{pass_q[0]}}) + DATA_W'(pass_q);

    assign addr_o     = addr_q;
    assign pass_o     = pass_q;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
    assign busy_o     = (state_q != S_IDLE) && (state_q != S_FINISH);

`ifndef MEMSEQ_READBACK_EN
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        load_a_o   = 1'b0;
        load_d_o   = 1'b0;
        write_o    = 1'b0;
        read_o     = 1'b0;
        done_o     = 1'b0;
        finish_o   = 1'b0;
        case (state_q)
            S_IDLE, S_FINISH: begin
                finish_o = (state_q == S_FINISH);
                if (start_i) begin
                    addr_d     = '0;
                    pass_d     = '0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                    state_d    = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                load_a_o = 1'b1;
                state_d  = S_LOAD_D;
            end
            S_LOAD_D: begin
                load_d_o = 1'b1;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                write_o = 1'b1;
                if (mem_done_i) begin
                    if (at_last) begin
                        addr_d = '0;
`ifdef MEMSEQ_READBACK_EN
                        state_d = S_RD_A;
`else
                        state_d = S_PASS_END;
`endif
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_LOAD_A;
                    end
                end
            end
`ifdef MEMSEQ_READBACK_EN
            S_RD_A: begin
                load_a_o = 1'b1;
                state_d  = S_READ;
            end
            S_READ: begin
                read_o = 1'b1;
                if (mem_done_i) begin
                    // Only the first mismatch of a run is recorded.
                    if ((rd_data_i != wdata_o) && !err_q) begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                    end
                    if (at_last) begin
                        state_d = S_PASS_END;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_RD_A;
                    end
                end
            end
`endif
            S_PASS_END: begin
                done_o = 1'b1;
                if (last_pass) begin
                    state_d = S_FINISH;
                end else begin
                    pass_d  = pass_q + 4'd1;
                    addr_d  = '0;
                    state_d = S_LOAD_A;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_pass_sched.sv
// Randomized bench for mem_pass_sched: an expected-operation queue per run is checked every cycle.
module tb_mem_pass_sched;
    localparam int AW = 4, DW = 15, LAST = 7, NP = 3;
`ifdef MEMSEQ_READBACK_EN
    localparam bit RB = 1'b1;
    // per pass: 8 addr * 3 write cycles + 8 * 2 read cycles = 40, then PASS_END
    localparam int DONE0 = 40, DONE1 = 81;
`else
    localparam bit RB = 1'b0;
    localparam int DONE0 = 24, DONE1 = 49;
`endif

    logic clk = 1'b0;
    logic rst_n, start, mem_done;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] addr_o, err_addr_o;
    logic [DW-1:0] wdata_o;
    logic load_a_o, load_d_o, write_o, read_o, busy_o, done_o, finish_o, err_o;
    logic [3:0] pass_o;

    always #5 clk = ~clk;

    mem_pass_sched #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(4'd7), .NUM_PASSES(NP)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mem_done_i(mem_done), .rd_data_i(rd_data),
        .addr_o(addr_o), .wdata_o(wdata_o), .load_a_o(load_a_o), .load_d_o(load_d_o),
        .write_o(write_o), .read_o(read_o), .pass_o(pass_o), .busy_o(busy_o), .done_o(done_o),
        .finish_o(finish_o), .err_o(err_o), .err_addr_o(err_addr_o)
    );

    typedef enum {K_LA, K_LD, K_WR, K_RA, K_RD, K_DN} kind_e;
    typedef struct {kind_e k; int a; int p;} item_t;

    item_t q[$];
    logic [DW-1:0] mem [0:LAST];
    int checks = 0, failures = 0;
    int cyc = 0, run_id = -1, mode = 0, wcnt = 0, wr_len = 0;
    int t_first = -1, n_done = 0;
    int d_ofs[2];
    bit m_fin = 0, m_err = 0;
    int m_pass = 0, m_addr = 0, m_err_addr = 0;
    bit start_req = 0, did_rst = 0, pin_rst = 0, pin_restart = 0, pinned_wd = 0;

    function automatic logic [DW-1:0] pat(int a, int p);
        logic [DW-1:0] av;
        av = DW'(a);
        if (p[0]) av = ~av;
        return av + DW'(p);
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic build_run();
        q.delete();
        for (int p = 0; p < NP; p++) begin
            for (int a = 0; a <= LAST; a++) begin
                q.push_back('{K_LA, a, p});
                q.push_back('{K_LD, a, p});
                q.push_back('{K_WR, a, p});
            end
            if (RB) begin
                for (int a = 0; a <= LAST; a++) begin
                    q.push_back('{K_RA, a, p});
                    q.push_back('{K_RD, a, p});
                end
            end
            q.push_back('{K_DN, RB ? LAST : 0, p});
        end
    endtask

    task automatic compare();
        item_t it;
        bit e_la = 0, e_ld = 0, e_wr = 0, e_rd = 0, e_dn = 0, e_busy = 0, e_fin = 0;
        int ea, ep;
        it = '{K_DN, 0, 0};
        if (q.size() == 0) begin
            ea = m_addr; ep = m_pass; e_fin = m_fin;
        end else begin
            it = q[0]; ea = it.a; ep = it.p; e_busy = 1;
            e_la = (it.k == K_LA) || (it.k == K_RA);
            e_ld = (it.k == K_LD);
            e_wr = (it.k == K_WR);
            e_rd = (it.k == K_RD);
            e_dn = (it.k == K_DN);
        end
        chk("busy", 64'(busy_o), 64'(e_busy));
        chk("load_a", 64'(load_a_o), 64'(e_la));
        chk("load_d", 64'(load_d_o), 64'(e_ld));
        chk("write", 64'(write_o), 64'(e_wr));
        chk("read", 64'(read_o), 64'(e_rd));
        chk("done", 64'(done_o), 64'(e_dn));
        chk("finish", 64'(finish_o), 64'(e_fin));
        chk("addr", 64'(addr_o), 64'(ea));
        chk("pass", 64'(pass_o), 64'(ep));
        chk("wdata", 64'(wdata_o), 64'(pat(ea, ep)));
        chk("err", 64'(err_o), 64'(m_err));
        chk("err_addr", 64'(err_addr_o), 64'(m_err_addr));
        if (q.size() > 0) begin
            if (run_id == 0 && it.k == K_LA && t_first < 0) t_first = cyc;
            if (run_id == 0 && done_o === 1'b1 && n_done < 2) begin
                d_ofs[n_done] = cyc - t_first;
                n_done++;
            end
            if (it.k == K_LD && it.a == 5 && it.p == 1 && !pinned_wd) begin
                chk("wdata_p1a5", 64'(wdata_o), 64'(15'h7FFB));
                pinned_wd = 1;
            end
            if (it.k == K_WR && write_o === 1'b1) wr_len++;
            if (pin_restart && it.k == K_LA) begin
                chk("restart_pass", 64'(pass_o), 64'd0);
                chk("restart_finish", 64'(finish_o), 64'd0);
                pin_restart = 0;
            end
        end
        if (pin_rst) begin
            chk("rst_busy", 64'(busy_o), 64'd0);
            chk("rst_addr", 64'(addr_o), 64'd0);
            chk("rst_pass", 64'(pass_o), 64'd0);
            chk("rst_strobes", 64'({load_a_o, load_d_o, write_o, read_o, done_o}), 64'd0);
            pin_rst = 0;
        end
    endtask

    task automatic advance();
        item_t it;
        if (!rst_n) begin
            q.delete();
            m_fin = 0; m_pass = 0; m_addr = 0; m_err = 0; m_err_addr = 0;
            wr_len = 0; wcnt = 0;
        end else if (q.size() == 0) begin
            if (start) begin
                build_run();
                m_fin = 0; m_err = 0; m_err_addr = 0; wr_len = 0; wcnt = 0;
            end
        end else begin
            it = q[0];
            case (it.k)
                K_WR: if (mem_done) begin
                    mem[it.a] = pat(it.a, it.p);
                    if (mode == 1) chk("write_len", 64'(wr_len), 64'd4);
                    wr_len = 0;
                    void'(q.pop_front());
                end
                K_RD: if (mem_done) begin
                    if (rd_data !== pat(it.a, it.p) && !m_err) begin
                        m_err = 1; m_err_addr = it.a;
                    end
                    void'(q.pop_front());
                end
                K_DN: begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_fin = 1; m_pass = it.p; m_addr = it.a;
                    end
                end
                default: void'(q.pop_front());
            endcase
        end
    endtask

    task automatic tick();
        bit ack_slot;
        @(posedge clk);
        #1;
        cyc++;
        compare();
        rst_n = 1'b1;
        if (run_id == 2 && !did_rst && q.size() > 0 && q[0].k == K_WR && q[0].p == 1) begin
            rst_n = 1'b0; did_rst = 1; pin_rst = 1;
        end
        if (q.size() == 0) start = start_req;
        else start = ($urandom_range(0, 15) == 0);
        start_req = 0;
        ack_slot = (q.size() > 0) && (q[0].k == K_WR || q[0].k == K_RD);
        case (mode)
            0: mem_done = 1'b1;
            1: begin
                if (ack_slot) begin
                    mem_done = (wcnt == 3);
                    wcnt = (wcnt == 3) ? 0 : wcnt + 1;
                end else mem_done = 1'($urandom_range(0, 1));
            end
            default: mem_done = ($urandom_range(0, 2) == 0);
        endcase
        rd_data = DW'($urandom);
        if (ack_slot && q[0].k == K_RD && mem_done) begin
            rd_data = mem[q[0].a];
            if (run_id == 0 && ((q[0].p == 0 && q[0].a == 2) || (q[0].p == 1 && q[0].a == 5)))
                rd_data = '0;
            else if (mode == 2 && $urandom_range(0, 9) == 0)
                rd_data = mem[q[0].a] ^ DW'($urandom_range(1, 100));
        end
        advance();
    endtask

    task automatic do_run(int id, int md, int budget);
        int n;
        run_id = id; mode = md; start_req = 1;
        tick();
        n = 0;
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("run_timeout", 64'(q.size()), 64'd0);
        q.delete();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_done = 1'b0; rd_data = '0;
        for (int i = 0; i <= LAST; i++) mem[i] = '0;
        repeat (3) tick();

        do_run(0, 0, 2000);
        chk("fin_level", 64'(finish_o), 64'd1);
        chk("fin_pass", 64'(pass_o), 64'(NP - 1));
        chk("fin_err", 64'(err_o), 64'(RB));
        chk("fin_err_addr", 64'(err_addr_o), RB ? 64'd2 : 64'd0);
        chk("done_count", 64'(n_done), 64'd2);
        chk("done0_ofs", 64'(d_ofs[0]), 64'(DONE0));
        chk("done1_ofs", 64'(d_ofs[1]), 64'(DONE1));

        pin_restart = 1;
        do_run(1, 1, 3000);
        chk("restart_pinned", 64'(pin_restart), 64'd0);

        do_run(2, 2, 3000);
        chk("reset_hit", 64'(did_rst), 64'd1);

        do_run(3, 2, 3000);
        chk("fin3_level", 64'(finish_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
